// File: rtl/mm_req_responder.sv
`default_nettype none
// ============================================================================
// Module      : mm_req_responder
// Description : Turns two-word requests from a FWFT request FIFO into single
//               register-bus transactions and returns a two-word response
//               (status header + data) into a response FIFO. Transactions that
//               are not acknowledged within TIMEOUT bus cycles are aborted and
//               answered with ERR_DATA and the timeout flag set.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT      bus cycles to wait for ack_i before aborting (2..65535)
//   ERR_DATA     read data returned for a timed-out transaction
// Ports
//   clk          single clock (bus_clk domain)
//   rst_n        active-low reset, asynchronous assert, synchronised release
//   req_dat_i    request FIFO data (first-word-fall-through)
//   req_empty_i  request FIFO empty
//   req_rden_o   request FIFO pop (word consumed in the same cycle)
//   req_open_i   host has the request stream open
//   resp_dat_o   response FIFO write data
//   resp_wren_o  response FIFO push
//   resp_full_i  response FIFO full
//   en_o, wr_o   register bus strobe and write flag
//   adr_o        register bus address
//   dat_o        register bus write data
//   dat_i        register bus read data (valid with ack_i)
//   ack_i        register bus acknowledge (may be combinational from en_o)
//   busy_o       high whenever a request is in progress
// Request  : word0 = {wr, 3'bx, adr[27:0]}, word1 = write data
// Response : word0 = {wr, timeout, 2'b00, adr[27:0]}, word1 = data
// ============================================================================
module mm_req_responder #(
   parameter int          TIMEOUT  = 256,
   parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   // request FIFO (FWFT)
   input  logic [31:0] req_dat_i,
   input  logic        req_empty_i,
   output logic        req_rden_o,
   input  logic        req_open_i,
   // response FIFO
   output logic [31:0] resp_dat_o,
   output logic        resp_wren_o,
   input  logic        resp_full_i,
   // register bus
   output logic        en_o,
   output logic        wr_o,
   output logic [27:0] adr_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   // status
   output logic        busy_o
);

   // Last counter value before the transaction is abandoned. The counter
   // starts at zero on BUS entry, so firing at TIMEOUT-1 gives exactly
   // TIMEOUT cycles with en_o high.
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_HDR1 = 3'd1,
      S_BUS  = 3'd2,
      S_RSP0 = 3'd3,
      S_RSP1 = 3'd4
   } state_t;

   // -------------------------------------------------------------------------
   // Reset synchroniser: assertion propagates immediately through the async
   // clear, release is delayed by two clk edges so every flop leaves reset on
   // the same edge.
   // -------------------------------------------------------------------------
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   // -------------------------------------------------------------------------
   // Transaction state
   // -------------------------------------------------------------------------
   state_t      state_q;
   logic        wr_q;        // latched write flag from header
   logic [27:0] adr_q;       // latched address from header
   logic [31:0] wdat_q;      // latched write data (second request word)
   logic [31:0] rdat_q;      // captured read data or ERR_DATA
   logic [15:0] to_cnt_q;    // cycles spent in BUS without ack
   logic        to_flag_q;   // last transaction timed out
   logic        en_q;        // registered bus strobe
   logic        busy_q;      // registered busy indication

   // Header bits [30:28] carry no meaning for this block.
   logic        w_unused_hdr;
   assign w_unused_hdr = ^req_dat_i[30:28];

   // Pop conditions are combinational so that the FWFT word is consumed in
   // the same cycle it is latched. Gating with the internal reset keeps the
   // pop low while the block is held in reset.
   logic w_pop_hdr;
   logic w_pop_dat;

   assign w_pop_hdr = (state_q == S_IDLE) && req_open_i && !req_empty_i;
   assign w_pop_dat = (state_q == S_HDR1) && req_open_i && !req_empty_i;

   assign req_rden_o = rst_int_n && (w_pop_hdr || w_pop_dat);

   // Pushes follow the response FIFO full flag directly so no word is ever
   // written into a full FIFO and a stall simply holds the state.
   logic w_in_rsp0;
   logic w_in_rsp1;

   assign w_in_rsp0   = (state_q == S_RSP0);
   assign w_in_rsp1   = (state_q == S_RSP1);
   assign resp_wren_o = (w_in_rsp0 || w_in_rsp1) && !resp_full_i;

   // Response data: status header first, then the data word. Writes echo the
   // written data regardless of timeout; reads return dat_i or ERR_DATA.
   always_comb begin
      resp_dat_o = 32'h0;
      if (w_in_rsp0) begin
         resp_dat_o = {wr_q, to_flag_q, 2'b00, adr_q};
      end else if (w_in_rsp1) begin
         resp_dat_o = wr_q ? wdat_q : rdat_q;
      end
   end

   // -------------------------------------------------------------------------
   // Main FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q   <= S_IDLE;
         wr_q      <= 1'b0;
         adr_q     <= 28'h0;
         wdat_q    <= 32'h0;
         rdat_q    <= 32'h0;
         to_cnt_q  <= 16'h0;
         to_flag_q <= 1'b0;
         en_q      <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (w_pop_hdr) begin
                  wr_q    <= req_dat_i[31];
                  adr_q   <= req_dat_i[27:0];
                  busy_q  <= 1'b1;
                  state_q <= S_HDR1;
               end
            end

            S_HDR1: begin
               // A closed stream abandons the half-received request; the
               // closure check wins over a pending data word.
               if (!req_open_i) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (!req_empty_i) begin
                  wdat_q    <= req_dat_i;
                  to_cnt_q  <= 16'h0;
                  to_flag_q <= 1'b0;
                  en_q      <= 1'b1;
                  state_q   <= S_BUS;
               end
            end

            S_BUS: begin
               // req_open_i is deliberately ignored here: a started bus
               // cycle always completes and answers.
               if (ack_i) begin
                  // Ack takes priority, even in the cycle the timeout fires.
                  rdat_q    <= dat_i;
                  to_flag_q <= 1'b0;
                  en_q      <= 1'b0;
                  state_q   <= S_RSP0;
               end else if (to_cnt_q == TO_LAST) begin
                  rdat_q    <= ERR_DATA;
                  to_flag_q <= 1'b1;
                  en_q      <= 1'b0;
                  state_q   <= S_RSP0;
               end else begin
                  to_cnt_q <= to_cnt_q + 16'd1;
               end
            end

            S_RSP0: begin
               if (!resp_full_i) begin
                  state_q <= S_RSP1;
               end
            end

            S_RSP1: begin
               if (!resp_full_i) begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end

            default: begin
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Bus outputs come straight from the latched request, so they are stable
   // for the whole BUS phase.
   assign en_o   = en_q;
   assign wr_o   = wr_q;
   assign adr_o  = adr_q;
   assign dat_o  = wdat_q;
   assign busy_o = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mm_req_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mm_req_responder
// Description : Directed testbench for mm_req_responder. Models the request
//               and response FIFOs with queues, applies a table of read/write
//               requests, then runs hand-written timeout, backpressure,
//               partial-request, reset and throughput sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mm_req_responder;

   localparam int TB_TIMEOUT = 8;

   logic        clk;
   logic        rst_n;
   logic [31:0] req_dat_i;
   logic        req_empty_i;
   logic        req_rden_o;
   logic        req_open_i;
   logic [31:0] resp_dat_o;
   logic        resp_wren_o;
   logic        resp_full_i;
   logic        en_o;
   logic        wr_o;
   logic [27:0] adr_o;
   logic [31:0] dat_o;
   logic [31:0] dat_i;
   logic        ack_i;
   logic        busy_o;

   logic        ack_en;
   logic [31:0] rd_data;

   int          checks;
   int          errors;

   logic [31:0] reqq[$];
   logic [31:0] rspq[$];
   int          tq[$];
   int          cyc;
   int          en_cnt;
   int          proto_err;
   int          hold_err;
   logic        en_prev;
   logic        bus_wr;
   logic [27:0] bus_adr;
   logic [31:0] bus_dat;

   mm_req_responder #(
      .TIMEOUT  (TB_TIMEOUT),
      .ERR_DATA (32'hFFFF_FFFF)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_dat_i   (req_dat_i),
      .req_empty_i (req_empty_i),
      .req_rden_o  (req_rden_o),
      .req_open_i  (req_open_i),
      .resp_dat_o  (resp_dat_o),
      .resp_wren_o (resp_wren_o),
      .resp_full_i (resp_full_i),
      .en_o        (en_o),
      .wr_o        (wr_o),
      .adr_o       (adr_o),
      .dat_o       (dat_o),
      .dat_i       (dat_i),
      .ack_i       (ack_i),
      .busy_o      (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave acknowledges in the same cycle as the strobe when enabled.
   assign ack_i = ack_en & en_o;
   assign dat_i = rd_data;

   task automatic upd_req();
      req_empty_i = (reqq.size() == 0);
      req_dat_i   = (reqq.size() != 0) ? reqq[0] : 32'h0;
   endtask

   task automatic push_req(input logic [31:0] w0, input logic [31:0] w1);
      reqq.push_back(w0);
      reqq.push_back(w1);
      upd_req();
   endtask

   // FIFO models and bus monitor: sample at the edge, apply queue updates
   // shortly after so the DUT sees stable FIFO outputs at the edge.
   always @(posedge clk) begin
      logic        s_rd;
      logic        s_wr;
      logic        s_en;
      logic [31:0] s_rdat;
      s_rd   = req_rden_o;
      s_wr   = resp_wren_o;
      s_en   = en_o;
      s_rdat = resp_dat_o;
      cyc    = cyc + 1;
      if (s_wr && resp_full_i) proto_err = proto_err + 1;
      if (s_rd && req_empty_i) proto_err = proto_err + 1;
      if (s_en) begin
         en_cnt = en_cnt + 1;
         if (!en_prev) begin
            bus_wr  = wr_o;
            bus_adr = adr_o;
            bus_dat = dat_o;
         end else if (wr_o !== bus_wr || adr_o !== bus_adr || dat_o !== bus_dat) begin
            hold_err = hold_err + 1;
         end
      end
      en_prev = s_en;
      #1;
      if (s_rd && reqq.size() != 0) begin
         void'(reqq.pop_front());
         upd_req();
      end
      if (s_wr) begin
         rspq.push_back(s_rdat);
         tq.push_back(cyc);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_rsp(input int n, input string name);
      int k;
      k = 0;
      while (rspq.size() < n && k < 300) begin
         @(negedge clk);
         k++;
      end
      checks = checks + 1;
      if (rspq.size() < n) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d responses expected %0d", name, rspq.size(), n);
      end
   endtask

   task automatic pop_chk(input string name, input logic [31:0] exp);
      logic [31:0] v;
      v = 32'hXXXX_XXXX;
      if (rspq.size() != 0) v = rspq.pop_front();
      check(name, v, exp);
   endtask

   typedef struct {
      logic [31:0] hdr;
      logic [31:0] wdat;
      logic [31:0] rdat;
      logic [31:0] exp0;
      logic [31:0] exp1;
      logic        exp_wr;
      logic [27:0] exp_adr;
      logic        chk_dat;
   } vec_t;

   vec_t vt[5];

   initial begin
      int k;
      vt[0] = '{32'h0000_0002, 32'h0000_0000, 32'h1234_5678,
                32'h0000_0002, 32'h1234_5678, 1'b0, 28'h000_0002, 1'b0};
      vt[1] = '{32'h8000_0002, 32'hCAFE_F00D, 32'h0000_0000,
                32'h8000_0002, 32'hCAFE_F00D, 1'b1, 28'h000_0002, 1'b1};
      vt[2] = '{32'h7FFF_FFFF, 32'h1111_1111, 32'hA5A5_A5A5,
                32'h0FFF_FFFF, 32'hA5A5_A5A5, 1'b0, 28'hFFF_FFFF, 1'b0};
      vt[3] = '{32'hF000_0000, 32'h0000_0000, 32'h5555_5555,
                32'h8000_0000, 32'h0000_0000, 1'b1, 28'h000_0000, 1'b1};
      vt[4] = '{32'h8ABC_DEF1, 32'hDEAD_BEEF, 32'h0000_0000,
                32'h8ABC_DEF1, 32'hDEAD_BEEF, 1'b1, 28'hABC_DEF1, 1'b1};

      checks = 0;  errors = 0;  cyc = 0;  en_cnt = 0;
      proto_err = 0;  hold_err = 0;  en_prev = 1'b0;
      bus_wr = 1'b0;  bus_adr = 28'h0;  bus_dat = 32'h0;
      rst_n = 1'b0;  req_open_i = 1'b1;  resp_full_i = 1'b0;
      ack_en = 1'b1;  rd_data = 32'h0;
      upd_req();

      // ---- reset state ----
      #12;
      check("rst_rden",  {31'h0, req_rden_o},  32'h0);
      check("rst_wren",  {31'h0, resp_wren_o}, 32'h0);
      check("rst_en",    {31'h0, en_o},        32'h0);
      check("rst_wr",    {31'h0, wr_o},        32'h0);
      check("rst_busy",  {31'h0, busy_o},      32'h0);
      check("rst_adr",   {4'h0, adr_o},        32'h0);
      check("rst_dat",   dat_o,                32'h0);
      check("rst_rdat",  resp_dat_o,           32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // ---- table-driven read/write requests ----
      for (int i = 0; i < 5; i++) begin
         rd_data = vt[i].rdat;
         en_cnt  = 0;
         push_req(vt[i].hdr, vt[i].wdat);
         wait_rsp(2, $sformatf("v%0d_wait", i));
         pop_chk($sformatf("v%0d_rsp0", i), vt[i].exp0);
         pop_chk($sformatf("v%0d_rsp1", i), vt[i].exp1);
         check($sformatf("v%0d_encnt", i), en_cnt, 32'd1);
         check($sformatf("v%0d_wr", i), {31'h0, bus_wr}, {31'h0, vt[i].exp_wr});
         check($sformatf("v%0d_adr", i), {4'h0, bus_adr}, {4'h0, vt[i].exp_adr});
         if (vt[i].chk_dat) check($sformatf("v%0d_dato", i), bus_dat, vt[i].wdat);
         repeat (2) @(negedge clk);
      end

      // ---- timeout: no ack, strobe held exactly TIMEOUT cycles ----
      ack_en = 1'b0;
      en_cnt = 0;
      push_req(32'h0000_0003, 32'h0000_0000);
      wait_rsp(2, "to_wait");
      pop_chk("to_rsp0", 32'h4000_0003);
      pop_chk("to_rsp1", 32'hFFFF_FFFF);
      check("to_encnt", en_cnt, TB_TIMEOUT);
      check("to_hold", hold_err, 32'd0);
      ack_en = 1'b1;
      repeat (2) @(negedge clk);

      // ---- backpressure: full response FIFO stalls, no second accept ----
      resp_full_i = 1'b1;
      rd_data = 32'h0BAD_CAFE;
      push_req(32'h0000_0005, 32'h0000_0000);
      push_req(32'h8000_0006, 32'h00C0_FFEE);
      repeat (25) @(negedge clk);
      check("bp_nopush", rspq.size(), 32'd0);
      check("bp_reqq",   reqq.size(), 32'd2);
      check("bp_busy",   {31'h0, busy_o}, 32'd1);
      resp_full_i = 1'b0;
      wait_rsp(4, "bp_wait");
      pop_chk("bp_r0", 32'h0000_0005);
      pop_chk("bp_r1", 32'h0BAD_CAFE);
      pop_chk("bp_r2", 32'h8000_0006);
      pop_chk("bp_r3", 32'h00C0_FFEE);
      repeat (2) @(negedge clk);

      // ---- partial request: header only, then stream closed ----
      en_cnt = 0;
      reqq.push_back(32'h0000_0004);
      upd_req();
      repeat (4) @(negedge clk);
      check("pr_busy", {31'h0, busy_o}, 32'd1);
      check("pr_popped", reqq.size(), 32'd0);
      req_open_i = 1'b0;
      repeat (4) @(negedge clk);
      check("pr_idle", {31'h0, busy_o}, 32'd0);
      check("pr_noen", en_cnt, 32'd0);
      check("pr_norsp", rspq.size(), 32'd0);
      req_open_i = 1'b1;
      repeat (2) @(negedge clk);

      // ---- reset in the middle of a bus cycle ----
      ack_en = 1'b0;
      push_req(32'h0000_0007, 32'h0000_0000);
      k = 0;
      while (!en_o && k < 50) begin
         @(negedge clk);
         k++;
      end
      check("rb_en_seen", {31'h0, en_o}, 32'd1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rb_en0",   {31'h0, en_o},   32'd0);
      check("rb_busy0", {31'h0, busy_o}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("rb_norsp", rspq.size(), 32'd0);
      ack_en = 1'b1;
      rd_data = 32'h600D_F00D;
      push_req(32'h0000_0009, 32'h0000_0000);
      wait_rsp(2, "rb_wait");
      pop_chk("rb_r0", 32'h0000_0009);
      pop_chk("rb_r1", 32'h600D_F00D);
      repeat (2) @(negedge clk);

      // ---- throughput: back-to-back requests, one per 5 cycles ----
      tq.delete();
      rd_data = 32'h0000_00AA;
      push_req(32'h0000_0010, 32'h0);
      push_req(32'h0000_0011, 32'h0);
      push_req(32'h0000_0012, 32'h0);
      wait_rsp(6, "tp_wait");
      if (tq.size() >= 6) begin
         check("tp_gap1", tq[2] - tq[0], 32'd5);
         check("tp_gap2", tq[4] - tq[2], 32'd5);
      end else begin
         check("tp_count", tq.size(), 32'd6);
      end
      pop_chk("tp_r0", 32'h0000_0010);
      pop_chk("tp_r1", 32'h0000_00AA);
      pop_chk("tp_r2", 32'h0000_0011);
      pop_chk("tp_r3", 32'h0000_00AA);
      pop_chk("tp_r4", 32'h0000_0012);
      pop_chk("tp_r5", 32'h0000_00AA);

      // ---- protocol monitors over the whole run ----
      repeat (3) @(negedge clk);
      check("proto", proto_err, 32'd0);
      check("hold",  hold_err,  32'd0);
      check("extra_rsp", rspq.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
